store_align_unit: RTL

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/riscv_mem_pkg.sv | 30 +++
 rtl/store_lane_shift.sv | 30 +++
 rtl/store_align_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions: store size encodings, store FSM states and
// the size-to-byte-enable mapping.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    ERR   = 2'b11
  } store_state_e;

  function automatic logic [3:0] size_mask(input mem_size_e size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane placement of store data and byte enables across a
// two-word window; the upper word is non-zero only for misaligned stores.
module store_lane_shift
  import riscv_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  output logic [31:0] lo_data_o,
  output logic [31:0] hi_data_o,
  output logic [3:0]  lo_be_o,
  output logic [3:0]  hi_be_o,
  output logic        misaligned_o
);

  logic [63:0] wide_s;
  logic [7:0]  be_wide_s;

  // Shift data by whole bytes and enables by lanes into a 64-bit window
  always_comb begin
    wide_s       = {32'd0, data_i} << {offset_i, 3'b000};
    be_wide_s    = {4'd0, size_mask(size_i)} << offset_i;
    lo_data_o    = wide_s[31:0];
    hi_data_o    = wide_s[63:32];
    lo_be_o      = be_wide_s[3:0];
    hi_be_o      = be_wide_s[7:4];
    misaligned_o = |be_wide_s[7:4];
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a sized store into one or two word-aligned
// memory write beats. Define STORE_MISALIGN_SPLIT_EN to split misaligned
// stores into two beats; otherwise they are rejected with misalign_err.
module store_align_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              misalign_err
);

  store_state_e      state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       hi_data_q, hi_data_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic              split_q, split_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  mem_size_e         size_s;
  logic [31:0]       lo_data_s, hi_data_s;
  logic [3:0]        lo_be_s, hi_be_s;
  logic              misaligned_s;
  logic [ADDR_W-1:0] word_addr_s;

  assign size_s      = mem_size_e'(req_size);
  assign word_addr_s = {req_addr[ADDR_W-1:2], 2'b00};

  store_lane_shift u_shift (
    .data_i       (req_data),
    .offset_i     (req_addr[1:0]),
    .size_i       (size_s),
    .lo_data_o    (lo_data_s),
    .hi_data_o    (hi_data_s),
    .lo_be_o      (lo_be_s),
    .hi_be_o      (hi_be_s),
    .misaligned_o (misaligned_s)
  );

  // Next-state and next-output decode for the store FSM
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
    split_d   = split_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (size_s == SIZE_ILL) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (misaligned_s) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            state_d   = BEAT0;
            valid_d   = 1'b1;
            addr_d    = word_addr_s;
            wdata_d   = lo_data_s;
            be_d      = lo_be_s;
            hi_data_d = hi_data_s;
            hi_be_d   = hi_be_s;
            split_d   = 1'b1;
`else
            state_d = ERR;
            err_d   = 1'b1;
`endif
          end else begin
            state_d   = BEAT0;
            valid_d   = 1'b1;
            addr_d    = word_addr_s;
            wdata_d   = lo_data_s;
            be_d      = lo_be_s;
            hi_data_d = 32'd0;
            hi_be_d   = 4'd0;
            split_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (mem_ready && split_q) begin
          // Address increment wraps naturally at 2^ADDR_W
          state_d = BEAT1;
          addr_d  = addr_q + ADDR_W'(32'd4);
          wdata_d = hi_data_q;
          be_d    = hi_be_q;
        end else if (mem_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          wdata_d = 32'd0;
          be_d    = 4'd0;
          done_d  = 1'b1;
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          wdata_d = 32'd0;
          be_d    = 4'd0;
          split_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = BEAT1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        wdata_d = 32'd0;
        be_d    = 4'd0;
        split_d = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any in-flight store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      hi_data_q <= 32'd0;
      hi_be_q   <= 4'd0;
      split_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
      split_q   <= split_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready    = ready_q;
  assign mem_valid    = valid_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign done         = done_q;
  assign misalign_err = err_q;

endmodule
